// File: rtl/inst_store_pkg.sv
// inst_store_pkg: shared instruction-store sizing, NOP word and FSM encoding
package inst_store_pkg;
    localparam int IS_DEPTH = 4;
    localparam int IS_WIDTH = 8;
    localparam logic [IS_WIDTH-1:0] IS_NOP = 8'h00;
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
endpackage

// File: rtl/inst_mem.sv
// inst_mem: DEPTH x WIDTH storage, one sync write port, one sync read port, no reset
module inst_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/inst_store.sv
// inst_store: loadable program store feeding the processor's instruction input
module inst_store
    import inst_store_pkg::*;
#(
    parameter int DEPTH = IS_DEPTH,
    parameter int WIDTH = IS_WIDTH,
    parameter logic [WIDTH-1:0] NOP = IS_NOP,
    parameter int AW = $clog2(DEPTH),
    parameter int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] instruction,
    output logic             loaded,
    output logic [CW-1:0]    ld_count
);
    state_t state, state_nx;
    logic we, rd_valid;
    logic [WIDTH-1:0] mem_q;
    always_comb begin
        state_nx = state;
        we = 1'b0;
        ld_ready = 1'b0;
        loaded = 1'b0;
        case (state)
            EMPTY: state_nx = ld_start ? LOADING : EMPTY;
            LOADING: begin
                ld_ready = 1'b1;
                we = ld_valid && !ld_start;
                state_nx = (we && ld_count == CW'(DEPTH - 1)) ? READY : LOADING;
            end
            READY: begin
                loaded = 1'b1;
                state_nx = ld_start ? LOADING : READY;
            end
            default: state_nx = EMPTY;
        endcase
    end
    // rd_valid masks the raw memory read so partial programs are never fetched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            ld_count <= '0;
            rd_valid <= 1'b0;
        end else begin
            state <= state_nx;
            ld_count <= ld_start ? '0 : we ? ld_count + CW'(1) : ld_count;
            rd_valid <= state == READY;
        end
    end
    assign instruction = rd_valid ? mem_q : NOP;
    inst_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
        .clk(clk),
        .we(we),
        .wr_addr(ld_count[AW-1:0]),
        .wr_data(ld_data),
        .rd_addr(rd_addr),
        .rd_data(mem_q)
    );
endmodule

// File: doc/inst_store.md
INST_STORE -- requirements
Module: inst_store

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries (power of two; address width = log2(DEPTH)).
REQ-002 Parameter WIDTH, default 8, instruction width in bits.
REQ-003 Parameter NOP, default 8'h00, word driven on instruction when no program is loaded.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 ld_start  input  1  pulse: discard current program and begin a new load.
REQ-007 ld_valid  input  1  ld_data carries a valid instruction word.
REQ-008 ld_data  input  WIDTH  instruction word to load.
REQ-009 ld_ready  output  1  store accepts a word this cycle.
REQ-010 rd_addr  input  log2(DEPTH)  fetch address driven by the processor's address register.
REQ-011 instruction  output  WIDTH  registered fetched word, consumed by the processor's instruction input.
REQ-012 loaded  output  1  high while a complete program is held.
REQ-013 ld_count  output  log2(DEPTH)+1  number of words accepted in the current load.

Function
REQ-014 The block SHALL implement a three-state FSM: EMPTY, LOADING, READY.
REQ-015 EMPTY: ld_ready=0, loaded=0; ld_start -> LOADING.
REQ-016 LOADING: ld_ready=1, loaded=0; a word is accepted only when ld_valid && ld_ready at the edge.
REQ-017 Accepted word SHALL be written to mem[wr_ptr]; wr_ptr and ld_count SHALL increment by 1.
REQ-018 When the DEPTH-th word is accepted, the FSM SHALL go to READY on that same edge; ld_count = DEPTH.
REQ-019 READY: ld_ready=0, loaded=1; ld_valid SHALL be ignored (no write, no pointer change).
REQ-020 ld_start in LOADING or READY SHALL return to LOADING with wr_ptr=0, ld_count=0, loaded=0.
REQ-021 ld_start and ld_valid in the same cycle: ld_start wins; ld_data is discarded, not written.
REQ-022 In READY, instruction SHALL register mem[rd_addr] each edge: one-cycle read latency.
REQ-023 In EMPTY and LOADING, instruction SHALL register NOP; partially loaded words are never fetched.
REQ-024 Transition LOADING->READY: instruction on the following edge reflects mem[rd_addr] of the completed program.
REQ-025 rd_addr wraps naturally (DEPTH-1 -> 0) with no special handling; any rd_addr value is legal.
REQ-026 ld_count SHALL saturate at DEPTH; wr_ptr SHALL never wrap within a single load.
REQ-027 Memory contents are not cleared by ld_start; they are overwritten entry by entry.

Reset
REQ-028 rst low SHALL asynchronously force: FSM=EMPTY, wr_ptr=0, ld_count=0, loaded=0, ld_ready=0, instruction=NOP.
REQ-029 Memory array SHALL NOT be reset; its contents are unobservable until a full load completes.
REQ-030 Reset mid-load SHALL abandon the load; a fresh ld_start is required after release.
REQ-031 Reset deassertion SHALL be synchronised to clk by the integrator; the block does not resynchronise.

Structure
REQ-032 FSM state encoding, DEPTH, WIDTH and NOP SHALL live in the shared processor package.
REQ-033 Storage SHALL be a sub-module inst_mem (DEPTH x WIDTH, one sync write port, one sync read port); FSM and pointers stay in inst_store.
REQ-034 inst_store SHALL be instantiated directly upstream of processor: rd_addr <- address, instruction -> instruction.

Verification
REQ-035 Reset then ld_start, load 8'h11,8'h22,8'h33,8'h44 back-to-back -> ld_ready high 4 cycles, loaded=1 after 4th, ld_count=4.
REQ-036 READY, rd_addr sweeps 0,1,2,3,0 -> instruction 8'h11,8'h22,8'h33,8'h44,8'h11, each one cycle after its address.
REQ-037 Load with ld_valid gaps (1-0-1-0-1-1) -> exactly 4 writes, no duplicates, ld_count monotonic, instruction=8'h00 throughout.
REQ-038 After 2 words, ld_start together with ld_valid/8'hAA -> ld_count=0, 8'hAA not stored; next 4 words form the program.
REQ-039 rst low for part of a cycle after 3 loaded words -> outputs reset immediately (not at edge), FSM EMPTY, ld_valid ignored until ld_start.
REQ-040 In READY, ld_valid with 8'hFF for 10 cycles -> no change to fetched words, ld_ready stays 0.
